// File: rtl/alu_pkg.sv
// Shared opcode, status-bit and FSM-state definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps per product.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod_next
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]        cnt_p0;
  logic [2*WIDTH-1:0]   acc_p0;
  logic [2*WIDTH-1:0]   mcand_p0;
  logic [WIDTH-1:0]     mplier_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0 <= '0;
    end else if (load) begin
      cnt_p0 <= '0;
    end else if (step) begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // Datapath registers: cleared/loaded on load, never needed across a reset.
  always_ff @(posedge clk) begin
    if (load) begin
      acc_p0    <= '0;
      mcand_p0  <= {{WIDTH{1'b0}}, a};
      mplier_p0 <= b;
    end else if (step) begin
      acc_p0    <= prod_next;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // prod_next already includes the current step, so the top can latch it on the final edge.
  assign prod_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign last      = step && (cnt_p0 == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with status flags and a start/busy/done multi-cycle multiply.
module alu_mc #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] loadc,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  state_t               state, state_n;
  logic                 load_res;
  logic [WIDTH-1:0]     res_n;
  logic [2:0]           stat_n;
  logic                 mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH-1:0]     loadc_p1;
  logic [2:0]           status_p1;
  logic                 vld_p1;

  function automatic logic [2:0] mk_flags(input logic [WIDTH-1:0] r, input logic v);
    logic [2:0] f;
    f       = '0;
    f[ST_Z] = (r == '0);
    f[ST_N] = r[WIDTH-1];
    f[ST_V] = v;
    return f;
  endfunction

  // Single-cycle operations; an unsupported opcode yields zero with V set.
  function automatic logic [WIDTH+2:0] exec_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH:0] ea, eb, w;
    logic [WIDTH-1:0]      r;
    logic                  v;
    ea = $signed({a[WIDTH-1], a});
    eb = $signed({b[WIDTH-1], b});
    w  = '0;
    r  = '0;
    v  = 1'b0;
    case (op)
      OP_ADD: begin w = ea + eb; r = w[WIDTH-1:0]; v = w[WIDTH] ^ w[WIDTH-1]; end
      OP_SUB: begin w = ea - eb; r = w[WIDTH-1:0]; v = w[WIDTH] ^ w[WIDTH-1]; end
      OP_AND: r = a & b;
      OP_NOT: r = ~b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = a << b[SHW-1:0];
      default: begin r = '0; v = 1'b1; end
    endcase
    return {mk_flags(r, v), r};
  endfunction

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_load),
    .step      (mul_step),
    .a         (ain),
    .b         (bin),
    .last      (mul_last),
    .prod_next (prod_next)
  );

  always_comb begin
    state_n  = state;
    load_res = 1'b0;
    res_n    = '0;
    stat_n   = '0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (ALUop == OP_MUL && MUL_EN) begin
            mul_load = 1'b1;
            state_n  = S_MUL;
          end else begin
            load_res        = 1'b1;
            {stat_n, res_n} = exec_op(ALUop, ain, bin);
          end
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          load_res = 1'b1;
          res_n    = prod_next[WIDTH-1:0];
          stat_n   = mk_flags(prod_next[WIDTH-1:0], |prod_next[2*WIDTH-1:WIDTH]);
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stage p1: registered result, flags and done strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      vld_p1    <= 1'b0;
      loadc_p1  <= '0;
      status_p1 <= '0;
    end else begin
      state  <= state_n;
      vld_p1 <= load_res;
      if (load_res) begin
        loadc_p1  <= res_n;
        status_p1 <= stat_n;
      end
    end
  end

  assign loadc  = loadc_p1;
  assign status = status_p1;
  assign done   = vld_p1;
  assign busy   = (state == S_MUL);

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: two instances (multiply enabled/disabled) share stimulus.
module tb_alu_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] ain, bin;
  logic [2:0]   ALUop;

  logic [W-1:0] loadc_w  [2];
  logic [2:0]   status_w [2];
  logic         busy_w   [2];
  logic         done_w   [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .ain(ain), .bin(bin), .ALUop(ALUop),
    .loadc(loadc_w[0]), .status(status_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  alu_mc #(.WIDTH(W), .MUL_EN(1'b0)) dut_n (
    .clk(clk), .reset(reset), .start(start), .ain(ain), .bin(bin), .ALUop(ALUop),
    .loadc(loadc_w[1]), .status(status_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference arithmetic from plain integer math; returns {V,N,Z,result}.
  function automatic logic [W+2:0] mdl(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input bit en);
    int              s;
    longint unsigned p;
    logic [W-1:0]    r;
    logic            v;
    s = 0; p = 0; r = '0; v = 1'b0;
    case (op)
      3'd0: begin s = int'($signed(a)) + int'($signed(b)); r = s[W-1:0]; v = (s > 32767) || (s < -32768); end
      3'd1: begin s = int'($signed(a)) - int'($signed(b)); r = s[W-1:0]; v = (s > 32767) || (s < -32768); end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = a << (b % W);
      default: begin
        if (en) begin
          p = longint'(a) * longint'(b);
          r = p[W-1:0];
          v = (p >> W) != 0;
        end else begin
          r = '0;
          v = 1'b1;
        end
      end
    endcase
    return {v, r[W-1], (r == '0), r};
  endfunction

  // Model: cycles-remaining counter per instance, results committed when it expires.
  logic [W-1:0] m_loadc [2];
  logic [W-1:0] p_loadc [2];
  logic [2:0]   m_st    [2];
  logic [2:0]   p_st    [2];
  int           m_busy  [2];
  logic         m_done  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_loadc[k] <= '0;
        m_st[k]    <= '0;
        m_busy[k]  <= 0;
        m_done[k]  <= 1'b0;
      end else if (m_busy[k] != 0) begin
        m_busy[k] <= m_busy[k] - 1;
        m_done[k] <= (m_busy[k] == 1);
        if (m_busy[k] == 1) begin
          m_loadc[k] <= p_loadc[k];
          m_st[k]    <= p_st[k];
        end
      end else if (start && ALUop == 3'b111 && k == 0) begin
        {p_st[k], p_loadc[k]} <= mdl(ALUop, ain, bin, 1'b1);
        m_busy[k] <= W;
        m_done[k] <= 1'b0;
      end else if (start) begin
        {m_st[k], m_loadc[k]} <= mdl(ALUop, ain, bin, k == 0);
        m_done[k] <= 1'b1;
      end else begin
        m_done[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_loadc%0d", k),  32'(loadc_w[k]),  32'(m_loadc[k]));
        chk($sformatf("cyc_status%0d", k), 32'(status_w[k]), 32'(m_st[k]));
        chk($sformatf("cyc_busy%0d", k),   32'(busy_w[k]),   32'(m_busy[k] != 0));
        chk($sformatf("cyc_done%0d", k),   32'(done_w[k]),   32'(m_done[k]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUop = op; ain = a; bin = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // n0 = edges already observed since the multiply was accepted.
  task automatic wait_mul(input string nm, input int n0, input logic [W-1:0] er, input logic [2:0] es);
    int n;
    n = n0;
    while (done_w[0] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_loadc"}, 32'(loadc_w[0]), 32'(er));
    chk({nm, "_status"}, 32'(status_w[0]), 32'(es));
    chk({nm, "_busy"}, 32'(busy_w[0]), 32'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; ain = '0; bin = '0; ALUop = 3'd0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_loadc",  32'(loadc_w[0]),  32'd0);
    chk("rst_status", 32'(status_w[0]), 32'd0);
    chk("rst_busy",   32'(busy_w[0]),   32'd0);
    chk("rst_done",   32'(done_w[0]),   32'd0);
    reset = 1'b0;
    step();

    go(3'd0, 16'h8889, 16'h2221);
    chk("add_loadc",  32'(loadc_w[0]),  32'h0000AAAA);
    chk("add_status", 32'(status_w[0]), 32'b010);
    chk("add_done",   32'(done_w[0]),   32'd1);
    chk("add_busy",   32'(busy_w[0]),   32'd0);
    step();
    chk("add_done_low", 32'(done_w[0]), 32'd0);

    ALUop = 3'd1; ain = 16'h2492; bin = 16'h2492; start = 1'b1;
    step();
    chk("sub_loadc",  32'(loadc_w[0]),  32'd0);
    chk("sub_status", 32'(status_w[0]), 32'b001);
    ALUop = 3'd0; ain = 16'h7FFF; bin = 16'h0001;
    step();
    start = 1'b0;
    chk("addv_loadc",  32'(loadc_w[0]),  32'h00008000);
    chk("addv_status", 32'(status_w[0]), 32'b110);
    chk("addv_done",   32'(done_w[0]),   32'd1);

    go(3'd1, 16'h8000, 16'h0001);
    chk("subv_loadc",  32'(loadc_w[0]),  32'h00007FFF);
    chk("subv_status", 32'(status_w[0]), 32'b100);
    go(3'd2, 16'hF0F0, 16'h3C3C);
    go(3'd4, 16'hF0F0, 16'h0F0F);
    go(3'd5, 16'hAAAA, 16'hAAAA);
    step();

    go(3'd7, 16'h0012, 16'h0034);
    chk("mul1_busy",     32'(busy_w[0]),   32'd1);
    chk("nomul_done",    32'(done_w[1]),   32'd1);
    chk("nomul_loadc",   32'(loadc_w[1]),  32'd0);
    chk("nomul_status",  32'(status_w[1]), 32'b101);
    step();
    step();
    ALUop = 3'd0; ain = 16'h0001; bin = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    wait_mul("mul1", 3, 16'h03A8, 3'b000);
    step();

    go(3'd7, 16'h0100, 16'h0100);
    chk("mul2_busy", 32'(busy_w[0]), 32'd1);
    wait_mul("mul2", 0, 16'h0000, 3'b101);

    go(3'd7, 16'hFFFF, 16'hFFFF);
    wait_mul("mul3", 0, 16'h0001, 3'b100);

    go(3'd7, 16'h00FF, 16'h00FF);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy",   32'(busy_w[0]),   32'd0);
    chk("rstmid_loadc",  32'(loadc_w[0]),  32'd0);
    chk("rstmid_status", 32'(status_w[0]), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_w[0] === 1'b1) ndone++;
      step();
    end
    chk("rstmid_nodone", ndone, 0);

    go(3'd3, 16'h1234, 16'h0000);
    chk("not_loadc",  32'(loadc_w[0]),  32'h0000FFFF);
    chk("not_status", 32'(status_w[0]), 32'b010);

    go(3'd6, 16'h0001, 16'h0013);
    chk("shl_loadc",  32'(loadc_w[0]),  32'h00000008);
    chk("shl_status", 32'(status_w[0]), 32'b000);

    go(3'd7, 16'h0005, 16'h0006);
    chk("nomul2_loadc",  32'(loadc_w[1]),  32'd0);
    chk("nomul2_status", 32'(status_w[1]), 32'b101);
    wait_mul("mul4", 0, 16'h001E, 3'b000);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
